clk_div_prog: RTL and testbench
===============================

Name: clk_div_prog

Overview:
- Programmable clock divider and pulse generator. It is the parametrised successor to the fixed divide-by-2 pixel-clock block.
- Derives a divided square wave (clk_out) and a one-cycle strobe (tick) from the 50 MHz board clock.
- The divisor can change at run time. A change takes effect glitch-free at a period boundary.
- Feeds VGA timing, which needs 25 MHz or slower test-pattern rates selectable without re-synthesis.

Parameters:
- CNT_WIDTH, 8: width of the divisor and the half-period counter.
- DEFAULT_DIV, 1: half-period length (in clk_in cycles) loaded at reset. The value 1 reproduces the legacy 25 MHz output. Legal range 1..2^CNT_WIDTH-1.

Ports:
- clk_in, input, 1: sole clock, 50 MHz, all logic rising-edge.
- rst_n, input, 1: asynchronous active-low reset.
- en, input, 1: count enable. Low freezes the divider.
- div_in, input, CNT_WIDTH: requested half-period N.
- div_load, input, 1: one-cycle request to capture div_in.
- clk_out, output, 1: divided clock, registered. Frequency f_clk_in/(2N), 50% duty.
- tick, output, 1: registered one-cycle pulse in each cycle where clk_out has just risen.
- busy, output, 1: a captured divisor is pending and not yet applied.
- load_err, output, 1: one-cycle pulse when div_load is asserted with div_in == 0.

Behaviour:
- Reset, asynchronous on rst_n low:
  - cnt = 0, clk_out = 0, tick = 0, busy = 0, load_err = 0.
  - Active divisor = DEFAULT_DIV, pending register = DEFAULT_DIV.
  - Outputs go to these values immediately, not on the next edge. A reset mid-period discards any pending divisor.
- Counting, each clk_in edge with en = 1:
  - If cnt == active_div-1: cnt <= 0 and clk_out toggles.
  - Otherwise cnt <= cnt+1.
- tick:
  - tick <= 1 exactly on the edge where clk_out toggles 0->1, else 0.
  - tick and clk_out rise in the same cycle, so tick period is 2N cycles.
- First edge after reset release, with en = 1 and N = 1: clk_out = 1 and tick = 1.
- en = 0:
  - cnt and clk_out hold their values and tick = 0.
  - Loads are still captured.
  - Resuming continues from the frozen count with no extra toggle.
- Divisor load:
  - div_load with div_in != 0: pending <= div_in, busy <= 1.
  - A second load while busy overwrites pending (last write wins).
  - div_load with div_in == 0: ignored, and load_err pulses for 1 cycle. Pending and busy are unchanged.
- Apply point:
  - On the edge where clk_out toggles 1->0 and busy == 1: active_div <= pending, busy <= 0, cnt <= 0.
  - The new divisor therefore governs both halves of the next full period. A partial period is never produced.
- Simultaneous load and apply on the same edge:
  - The old pending value is applied.
  - The new div_in becomes pending and busy stays 1.
- Widths:
  - cnt is CNT_WIDTH bits. The compare uses active_div-1 in CNT_WIDTH bits.
  - No wrap beyond active_div-1 is possible because active_div >= 1 always.
- Latency:
  - Outputs are registered, one cycle after the causing edge.
  - Maximum load-to-effect latency is 2N cycles of the old divisor.

Decomposition:
- No shared package needed.
- A localparam for the all-zero divisor compare stays local.
- Single module. The counter, toggle, pending register and apply logic are too tightly coupled to split usefully.

Test Plan:
- Reset default, legacy mode: DEFAULT_DIV = 1, en = 1, release rst_n.
  - clk_out toggles every clk_in edge, giving 25 MHz with a 40 ns period.
  - tick is high in every other cycle, aligned with clk_out high.
- Runtime load: load div_in = 3 mid-high-phase.
  - busy = 1 until the next clk_out fall.
  - From then on, clk_out is 3 cycles high and 3 cycles low (120 ns period).
  - tick is spaced 6 cycles apart.
  - No period shorter than 2 cycles occurs during the switch.
- Overwrite and collision:
  - Load 5, then load 2 before the apply point: only 2 takes effect.
  - Load 7 on the exact apply edge of a pending 4: period becomes 8 cycles and busy stays 1.
  - After that, period becomes 14 cycles and busy drops to 0.
- Zero divisor: with N = 3 running, pulse div_load with div_in = 0.
  - load_err is high for exactly 1 cycle and busy stays 0.
  - Period remains 6 cycles.
- Enable freeze: with N = 4, drop en for 10 cycles at cnt = 2 while clk_out = 1.
  - clk_out holds 1 and tick stays 0.
  - After en returns, clk_out falls exactly 2 enabled cycles later.
- Asynchronous reset mid-operation: assert rst_n low between clk_in edges while busy = 1 and clk_out = 1.
  - clk_out, tick and busy go to 0 immediately.
  - After release, the divider runs at DEFAULT_DIV and the old pending value is lost.

Source files
------------

// File: rtl/clk_div_prog.sv
// Programmable clock divider: divided square wave, rising-edge strobe and a
// run-time divisor that is only switched in at the end of a full period.
module clk_div_prog #(
    parameter int unsigned CNT_WIDTH   = 8,
    parameter int unsigned DEFAULT_DIV = 1
) (
    input  logic                 clk_in,
    input  logic                 rst_n,
    input  logic                 en,
    input  logic [CNT_WIDTH-1:0] div_in,
    input  logic                 div_load,
    output logic                 clk_out,
    output logic                 tick,
    output logic                 busy,
    output logic                 load_err
);

    localparam logic [CNT_WIDTH-1:0] DIV_ZERO  = '0;
    localparam logic [CNT_WIDTH-1:0] DIV_RESET = CNT_WIDTH'(DEFAULT_DIV);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE   = CNT_WIDTH'(1);

    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic [CNT_WIDTH-1:0] active_div_q, active_div_d;
    logic [CNT_WIDTH-1:0] pending_q, pending_d;
    logic                 clk_out_q, clk_out_d;
    logic                 tick_q, tick_d;
    logic                 busy_q, busy_d;
    logic                 load_err_q, load_err_d;

    logic wrap;
    logic fall;
    logic apply;
    logic load_ok;

    always_comb begin
        wrap    = en && (cnt_q == (active_div_q - CNT_ONE));
        fall    = wrap && clk_out_q;
        apply   = fall && busy_q;
        load_ok = div_load && (div_in != DIV_ZERO);

        cnt_d        = cnt_q;
        clk_out_d    = clk_out_q;
        active_div_d = active_div_q;
        pending_d    = pending_q;
        busy_d       = busy_q;
        tick_d       = wrap && !clk_out_q;
        load_err_d   = div_load && (div_in == DIV_ZERO);

        if (en) begin
            if (wrap) begin
                cnt_d     = '0;
                clk_out_d = ~clk_out_q;
            end else begin
                cnt_d = cnt_q + CNT_ONE;
            end
        end

        // Switch only on a falling edge so the new divisor owns a whole period.
        if (apply) begin
            active_div_d = pending_q;
            busy_d       = 1'b0;
            cnt_d        = '0;
        end

        // A load on the apply edge queues behind the value being applied.
        if (load_ok) begin
            pending_d = div_in;
            busy_d    = 1'b1;
        end
    end

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q        <= '0;
            clk_out_q    <= 1'b0;
            tick_q       <= 1'b0;
            busy_q       <= 1'b0;
            load_err_q   <= 1'b0;
            active_div_q <= DIV_RESET;
            pending_q    <= DIV_RESET;
        end else begin
            cnt_q        <= cnt_d;
            clk_out_q    <= clk_out_d;
            tick_q       <= tick_d;
            busy_q       <= busy_d;
            load_err_q   <= load_err_d;
            active_div_q <= active_div_d;
            pending_q    <= pending_d;
        end
    end

    assign clk_out  = clk_out_q;
    assign tick     = tick_q;
    assign busy     = busy_q;
    assign load_err = load_err_q;

endmodule

// File: tb/tb_clk_div_prog.sv
// Bench for clk_div_prog: a directed vector table plus a cycle model whose
// predictions go through a scoreboard queue, and period measurements.
module tb_clk_div_prog;

    localparam int unsigned W = 8;

    logic         clk_in = 1'b0;
    logic         rst_n = 1'b1;
    logic         en = 1'b0;
    logic         div_load = 1'b0;
    logic [W-1:0] div_in = '0;
    logic         clk_out, tick, busy, load_err;

    always #10 clk_in = ~clk_in;

    clk_div_prog #(
        .CNT_WIDTH  (W),
        .DEFAULT_DIV(1)
    ) dut (
        .clk_in  (clk_in),
        .rst_n   (rst_n),
        .en      (en),
        .div_in  (div_in),
        .div_load(div_load),
        .clk_out (clk_out),
        .tick    (tick),
        .busy    (busy),
        .load_err(load_err)
    );

    typedef struct packed {
        logic clk;
        logic tck;
        logic bsy;
        logic err;
    } out_t;

    typedef struct {
        logic         e;
        logic         ld;
        logic [W-1:0] din;
        out_t         exp;
    } vec_t;

    out_t sb_q[$];
    int   n_checks = 0;
    int   n_fail = 0;

    // Reference model state
    int m_cnt, m_act, m_pend;
    bit m_clk, m_tick, m_busy, m_err;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_cnt  = 0;
        m_clk  = 0;
        m_tick = 0;
        m_busy = 0;
        m_err  = 0;
        m_act  = 1;
        m_pend = 1;
    endtask

    task automatic model_step(input logic e, input logic ld, input logic [W-1:0] d,
                              output out_t o);
        bit wrap, fall;
        wrap   = e && (m_cnt == m_act - 1);
        fall   = wrap && m_clk;
        m_tick = wrap && !m_clk;
        m_err  = ld && (d == 0);
        if (e) begin
            if (wrap) begin
                m_cnt = 0;
                m_clk = !m_clk;
            end else begin
                m_cnt++;
            end
        end
        if (fall && m_busy) begin
            m_act  = m_pend;
            m_busy = 0;
            m_cnt  = 0;
        end
        if (ld && d != 0) begin
            m_pend = int'(d);
            m_busy = 1;
        end
        o.clk = m_clk;
        o.tck = m_tick;
        o.bsy = m_busy;
        o.err = m_err;
    endtask

    task automatic drive_edge(input logic e, input logic ld, input logic [W-1:0] d,
                              input out_t exp);
        out_t got, want;
        en       = e;
        div_load = ld;
        div_in   = d;
        sb_q.push_back(exp);
        @(posedge clk_in);
        #1;
        got = {clk_out, tick, busy, load_err};
        if (sb_q.size() == 0) begin
            check("scoreboard empty", 1, 0);
        end else begin
            want = sb_q.pop_front();
            check("scoreboard {clk,tick,busy,err}", 32'(got), 32'(want));
        end
    endtask

    task automatic cycle(input logic e, input logic ld, input logic [W-1:0] d);
        out_t o;
        model_step(e, ld, d, o);
        drive_edge(e, ld, d, o);
    endtask

    task automatic sync_fall();
        bit prev, done;
        int n;
        prev = clk_out;
        done = 0;
        n    = 0;
        while (!done && n < 600) begin
            cycle(1, 0, '0);
            n++;
            if (prev === 1'b1 && clk_out === 1'b0) done = 1;
            prev = clk_out;
        end
        check("sync_fall timeout", 32'(done), 1);
    endtask

    task automatic fall_period(input string name, input int exp_len, input int exp_hi);
        bit prev, done;
        int n, hi;
        prev = clk_out;
        done = 0;
        n    = 0;
        hi   = 0;
        while (!done && n < 600) begin
            cycle(1, 0, '0);
            n++;
            if (clk_out === 1'b1) hi++;
            if (prev === 1'b1 && clk_out === 1'b0) done = 1;
            prev = clk_out;
        end
        check({name, " length"}, 32'(n), 32'(exp_len));
        check({name, " high"}, 32'(hi), 32'(exp_hi));
    endtask

    task automatic tick_gap(input string name, input int exp_gap);
        int n, gap;
        n = 0;
        while (tick !== 1'b1 && n < 600) begin
            cycle(1, 0, '0);
            n++;
        end
        gap = 0;
        do begin
            cycle(1, 0, '0);
            gap++;
        end while (tick !== 1'b1 && gap < 600);
        check(name, 32'(gap), 32'(exp_gap));
    endtask

    task automatic quiet_reset();
        #4 rst_n = 1'b0;
        #10 rst_n = 1'b1;
        model_reset();
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[14];
        out_t dummy;
        int   n, bad_hold;

        vecs[0]  = '{1'b1, 1'b0, 8'd0, 4'b1100};
        vecs[1]  = '{1'b1, 1'b0, 8'd0, 4'b0000};
        vecs[2]  = '{1'b1, 1'b0, 8'd0, 4'b1100};
        vecs[3]  = '{1'b1, 1'b0, 8'd0, 4'b0000};
        vecs[4]  = '{1'b1, 1'b1, 8'd0, 4'b1101};
        vecs[5]  = '{1'b1, 1'b0, 8'd0, 4'b0000};
        vecs[6]  = '{1'b1, 1'b1, 8'd2, 4'b1110};
        vecs[7]  = '{1'b1, 1'b0, 8'd0, 4'b0000};
        vecs[8]  = '{1'b1, 1'b0, 8'd0, 4'b0000};
        vecs[9]  = '{1'b1, 1'b0, 8'd0, 4'b1100};
        vecs[10] = '{1'b0, 1'b0, 8'd0, 4'b1000};
        vecs[11] = '{1'b0, 1'b1, 8'd6, 4'b1010};
        vecs[12] = '{1'b1, 1'b0, 8'd0, 4'b1010};
        vecs[13] = '{1'b1, 1'b0, 8'd0, 4'b0000};

        #2 rst_n = 1'b0;
        #3;
        check("reset outputs", 32'({clk_out, tick, busy, load_err}), 0);
        #30 rst_n = 1'b1;
        model_reset();

        // Legacy divide-by-2, zero load, small load, freeze with load
        for (int i = 0; i < 14; i++) begin
            model_step(vecs[i].e, vecs[i].ld, vecs[i].din, dummy);
            drive_edge(vecs[i].e, vecs[i].ld, vecs[i].din, vecs[i].exp);
        end

        // Runtime load of 3 during the high phase
        quiet_reset();
        cycle(1, 0, '0);
        cycle(1, 0, '0);
        cycle(1, 0, '0);
        check("legacy high before load", 32'(clk_out), 1);
        cycle(1, 1, 8'd3);
        check("busy after load 3", 32'(busy), 1);
        sync_fall();
        check("busy cleared at apply", 32'(busy), 0);
        fall_period("n3 period", 6, 3);
        tick_gap("n3 tick gap", 6);

        // Zero divisor rejected
        cycle(1, 1, 8'd0);
        check("load_err pulse", 32'(load_err), 1);
        check("busy after zero load", 32'(busy), 0);
        cycle(1, 0, '0);
        check("load_err one cycle", 32'(load_err), 0);
        sync_fall();
        fall_period("n3 after zero", 6, 3);

        // Overwrite: 5 then 2 inside the same period
        cycle(1, 1, 8'd5);
        cycle(1, 1, 8'd2);
        sync_fall();
        check("busy after overwrite apply", 32'(busy), 0);
        fall_period("n2 period", 4, 2);

        // Collision: load 7 on the apply edge of a pending 4
        cycle(1, 1, 8'd4);
        n = 0;
        while (!(m_clk && m_cnt == m_act - 1) && n < 50) begin
            cycle(1, 0, '0);
            n++;
        end
        cycle(1, 1, 8'd7);
        check("busy after collision", 32'(busy), 1);
        fall_period("n4 period", 8, 4);
        check("busy after second apply", 32'(busy), 0);
        fall_period("n7 period", 14, 7);

        // Freeze with N = 4 at cnt 2 while high
        cycle(1, 1, 8'd4);
        sync_fall();
        n = 0;
        while (!(m_clk && m_cnt == 2) && n < 50) begin
            cycle(1, 0, '0);
            n++;
        end
        bad_hold = 0;
        for (int i = 0; i < 10; i++) begin
            cycle(0, 0, '0);
            if (clk_out !== 1'b1 || tick !== 1'b0) bad_hold++;
        end
        check("freeze hold", 32'(bad_hold), 0);
        fall_period("resume to fall", 2, 1);

        // Asynchronous reset while busy and high
        cycle(1, 1, 8'd9);
        n = 0;
        while (!m_clk && n < 50) begin
            cycle(1, 0, '0);
            n++;
        end
        check("high and busy before reset", 32'({clk_out, busy}), 3);
        #4 rst_n = 1'b0;
        #1;
        check("async reset immediate", 32'({clk_out, tick, busy, load_err}), 0);
        model_reset();
        @(posedge clk_in);
        #5 rst_n = 1'b1;
        cycle(1, 0, '0);
        cycle(1, 0, '0);
        sync_fall();
        fall_period("post-reset period", 2, 1);
        check("pending lost after reset", 32'(busy), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
